// File: rtl/div_radix2_pkg.sv
// Shared constants for the radix-2 restoring divider: FSM state encodings and
// the per-operation iteration count.
package div_radix2_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_CALC = 2'd2,
        DIV_END  = 2'd3
    } div_state_e;

    localparam int DIV_CYCLES = 32;

endpackage

// File: rtl/div_radix2_if.sv
// Start/ready divide handshake between the E-stage initiator (master) and the
// divider (slave).
interface div_radix2_if
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
);
    logic                 signed_div;
    logic [WIDTH-1:0]     opdata1;
    logic [WIDTH-1:0]     opdata2;
    logic                 start;
    logic                 annul;
    logic [2*WIDTH-1:0]   result;
    logic                 ready;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready
    );
endinterface

// File: rtl/div_radix2_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and keep the trial difference when it is non-negative.
module div_radix2_step
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);
    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    // Trial subtract; a set top bit of trial_s means the divisor did not fit.
    always_comb begin
        shifted_s = {rem, shift_in};
        trial_s   = shifted_s - {1'b0, divisor};
        if (trial_s[WIDTH] == 1'b0) begin
            next_rem = trial_s[WIDTH-1:0];
            q_bit    = 1'b1;
        end else begin
            next_rem = shifted_s[WIDTH-1:0];
            q_bit    = 1'b0;
        end
    end
endmodule

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result is
// {remainder, quotient}, ready after WIDTH+1 cycles (2 for divide-by-zero).
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    div_radix2_if.slave   bus
);
    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    div_state_e         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   dvd_r;
    logic [WIDTH-1:0]   dsr_r;
    logic               sign_q_r;
    logic               sign_rem_r;
    logic [2*WIDTH-1:0] result_r;
    logic               ready_r;

    logic [WIDTH-1:0]   next_rem_s;
    logic               q_bit_s;
    logic [WIDTH-1:0]   quo_next_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;

    // Magnitude of an operand; only signed divides take the two's complement.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic en);
        if (en && x[WIDTH-1]) begin
            mag = ~x + ONE;
        end else begin
            mag = x;
        end
    endfunction

    div_radix2_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .shift_in (dvd_r[WIDTH-1]),
        .divisor  (dsr_r),
        .next_rem (next_rem_s),
        .q_bit    (q_bit_s)
    );

    // Quotient bits shift in behind the dividend bits being consumed.
    always_comb begin
        quo_next_s = {dvd_r[WIDTH-2:0], q_bit_s};
        if (sign_rem_r) begin
            rem_fix_s = ~next_rem_s + ONE;
        end else begin
            rem_fix_s = next_rem_s;
        end
        if (sign_q_r) begin
            quo_fix_s = ~quo_next_s + ONE;
        end else begin
            quo_fix_s = quo_next_s;
        end
    end

    // Control FSM and datapath registers; annul always wins and leaves result untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= DIV_IDLE;
            cnt_r      <= '0;
            rem_r      <= '0;
            dvd_r      <= '0;
            dsr_r      <= '0;
            sign_q_r   <= 1'b0;
            sign_rem_r <= 1'b0;
            result_r   <= '0;
            ready_r    <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    ready_r <= 1'b0;
                    if (bus.annul) begin
                        state_r <= DIV_IDLE;
                    end else if (bus.start) begin
                        sign_q_r   <= bus.signed_div & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                        sign_rem_r <= bus.signed_div & bus.opdata1[WIDTH-1];
                        dvd_r      <= mag(bus.opdata1, bus.signed_div);
                        dsr_r      <= mag(bus.opdata2, bus.signed_div);
                        rem_r      <= '0;
                        cnt_r      <= '0;
                        state_r    <= (bus.opdata2 == '0) ? DIV_ZERO : DIV_CALC;
                    end else begin
                        state_r <= DIV_IDLE;
                    end
                end
                DIV_ZERO: begin
                    if (bus.annul) begin
                        state_r <= DIV_IDLE;
                        ready_r <= 1'b0;
                    end else begin
                        result_r <= '0;
                        ready_r  <= 1'b1;
                        state_r  <= DIV_END;
                    end
                end
                DIV_CALC: begin
                    if (bus.annul) begin
                        state_r <= DIV_IDLE;
                        ready_r <= 1'b0;
                    end else begin
                        rem_r <= next_rem_s;
                        dvd_r <= quo_next_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(WIDTH - 1)) begin
                            result_r <= {rem_fix_s, quo_fix_s};
                            ready_r  <= 1'b1;
                            state_r  <= DIV_END;
                        end else begin
                            state_r <= DIV_CALC;
                        end
                    end
                end
                DIV_END: begin
                    if (bus.annul || !bus.start) begin
                        state_r <= DIV_IDLE;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= DIV_END;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= DIV_IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result = result_r;
    assign bus.ready  = ready_r;
endmodule

// File: tb/tb_div_radix2.sv
// Directed and random checks of div_radix2 against an arithmetic reference
// model built from magnitudes and sign rules.
module tb_div_radix2;
    import div_radix2_pkg::*;

    localparam int W = DIV_CYCLES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [63:0] last_res = 64'h0;

    div_radix2_if #(.WIDTH(W)) bus ();

    div_radix2 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: divide magnitudes, then negate quotient/remainder by the sign rules.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub, q, r;
        logic [31:0] q32, r32;
        if (b == 32'd0) return 64'h0;
        ua  = (sd && a[31]) ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
        ub  = (sd && b[31]) ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
        q   = ua / ub;
        r   = ua % ub;
        q32 = q[31:0];
        r32 = r[31:0];
        if (sd && (a[31] ^ b[31])) q32 = 32'd0 - q32;
        if (sd && a[31])           r32 = 32'd0 - r32;
        return {r32, q32};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one division with start held until ready, then drop start.
    task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int lat, input bit scramble);
        int n;
        bit got;
        bus.signed_div = sd;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.start      = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            step();
            n++;
            if (scramble && n == 1) begin
                bus.opdata1    = $urandom;
                bus.opdata2    = $urandom;
                bus.signed_div = ~sd;
            end
            got = (bus.ready === 1'b1);
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " result"}, bus.result, exp);
        bus.start = 1'b0;
        step();
        chk({tag, " ready drop"}, {63'h0, bus.ready}, 64'h0);
        last_res = exp;
    endtask

    initial begin
        logic        sd;
        logic [31:0] a, b;
        bit          seen;

        bus.signed_div = 1'b0;
        bus.opdata1    = 32'h0;
        bus.opdata2    = 32'h0;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;
        repeat (3) step();
        chk("reset ready", {63'h0, bus.ready}, 64'h0);
        chk("reset result", bus.result, 64'h0);
        rst = 1'b0;
        step();

        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b0);
        run_div("div -7/2", 1'b1, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
        run_div("div 7/-2", 1'b1, 32'h7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1'b0);
        run_div("div ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1'b0);
        run_div("divu max/1", 1'b0, 32'hFFFFFFFF, 32'h1, 64'h00000000_FFFFFFFF, 33, 1'b0);
        run_div("divu x/0", 1'b0, 32'h1234, 32'h0, 64'h0, 2, 1'b0);
        run_div("div -5/0", 1'b1, 32'hFFFFFFFB, 32'h0, 64'h0, 2, 1'b0);

        // Flush mid-calculation: no ready, result retained, FSM back in IDLE.
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd1000;
        bus.opdata2    = 32'd9;
        bus.start      = 1'b1;
        repeat (10) step();
        bus.annul = 1'b1;
        bus.start = 1'b0;
        step();
        bus.annul = 1'b0;
        chk("annul ready", {63'h0, bus.ready}, 64'h0);
        seen = 1'b0;
        repeat (40) begin
            step();
            if (bus.ready === 1'b1) seen = 1'b1;
        end
        chk("annul no late ready", {63'h0, seen}, 64'h0);
        chk("annul result kept", bus.result, last_res);
        run_div("after annul 20/3", 1'b0, 32'd20, 32'd3, 64'h00000002_00000006, 33, 1'b0);

        // annul beats start while idle.
        bus.start = 1'b1;
        bus.annul = 1'b1;
        repeat (3) step();
        bus.annul = 1'b0;
        chk("idle annul priority", {63'h0, bus.ready}, 64'h0);
        run_div("after idle annul", 1'b1, 32'hFFFFFF9C, 32'd7, model(1'b1, 32'hFFFFFF9C, 32'd7), 33, 1'b0);

        // Reset mid-operation abandons silently.
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd12345;
        bus.opdata2    = 32'd17;
        bus.start      = 1'b1;
        repeat (15) step();
        rst       = 1'b1;
        bus.start = 1'b0;
        step();
        chk("mid rst ready", {63'h0, bus.ready}, 64'h0);
        chk("mid rst result", bus.result, 64'h0);
        rst = 1'b0;
        last_res = 64'h0;
        step();

        run_div("scrambled ops", 1'b1, 32'hFFFF0000, 32'h123, model(1'b1, 32'hFFFF0000, 32'h123), 33, 1'b1);
        run_div("scrambled zero", 1'b0, 32'hDEAD, 32'h0, 64'h0, 2, 1'b1);

        for (int i = 0; i < 24; i++) begin
            sd = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'h0;
                default: b = 32'd0 - 32'($urandom_range(1, 15));
            endcase
            run_div($sformatf("rand%0d", i), sd, a, b, model(sd, a, b),
                    (b == 32'h0) ? 2 : 33, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
